// File: rtl/coh_pkg.sv
// Shared definitions for the directory-based coherence slice.
// Holds the MSI line-state encoding, the directory request and snoop
// type codes, the controller FSM states and the address/data widths
// used by the processor-side cache controller and its request buffer.
package coh_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // MSI state of a cache line
    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_M = 2'd2
    } line_state_e;

    // Directory request codes
    localparam logic [1:0] REQ_GETS = 2'b00;
    localparam logic [1:0] REQ_GETM = 2'b01;
    localparam logic [1:0] REQ_PUTM = 2'b10;

    // Snoop type codes
    localparam logic SNP_INV = 1'b0;
    localparam logic SNP_DWN = 1'b1;

    // Controller FSM states
    typedef enum logic [2:0] {
        FSM_IDLE      = 3'd0,
        FSM_LOOKUP    = 3'd1,
        FSM_MISS_WB   = 3'd2,
        FSM_MISS_REQ  = 3'd3,
        FSM_WAIT_RESP = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/req_fifo.sv
// Request buffer between the processor request stream and the cache FSM.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   push_i, data_i   write an entry (ignored when full unless popping too)
//   pop_i            remove the head entry
//   data_o           head entry (valid when !empty_o)
//   full_o, empty_o  occupancy flags
// Pointers wrap naturally because DEPTH is a power of two.
module req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];

    // A push while full is only taken when the head leaves in the same cycle
    assign doPush = push_i && (!full_o || pop_i);
    assign doPop  = pop_i && !empty_o;

    // Storage needs no reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/p1_cache_ctrl.sv
// Private MSI cache controller for processor 1.
// Buffers processor requests, serves them from a direct-mapped cache and
// fetches/upgrades/writes back lines through the home directory. Also
// answers directory invalidate/downgrade snoops.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/operationP1/
//   addressP1/dataP1               processor request stream
//   rd_done/rd_data, wr_done       completion pulses
//   overflow                       sticky dropped-request flag
//   dir_req_*                      request channel to the directory
//   dir_resp_valid/dir_resp_data   fill/grant from the directory
//   snp_*                          snoop channel and dirty-data return
module p1_cache_ctrl
    import coh_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              operationP1,
    input  logic [ADDR_W-1:0] addressP1,
    input  logic [DATA_W-1:0] dataP1,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic              overflow,
    output logic              dir_req_valid,
    input  logic              dir_req_ready,
    output logic [1:0]        dir_req_type,
    output logic [ADDR_W-1:0] dir_req_addr,
    output logic [DATA_W-1:0] dir_req_data,
    input  logic              dir_resp_valid,
    input  logic [DATA_W-1:0] dir_resp_data,
    input  logic              snp_valid,
    input  logic              snp_type,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_ready,
    output logic              snp_wb_valid,
    output logic [DATA_W-1:0] snp_wb_data
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    ctrl_state_e       state_q;
    line_state_e       lineState_q [NUM_LINES];
    logic [TAG_W-1:0]  lineTag_q   [NUM_LINES];
    logic [DATA_W-1:0] lineData_q  [NUM_LINES];

    logic              curWrite_q;
    logic [ADDR_W-1:0] curAddr_q;
    logic [DATA_W-1:0] curData_q;

    logic              rdDone_q;
    logic [DATA_W-1:0] rdData_q;
    logic              wrDone_q;
    logic              overflow_q;
    logic              dirReqValid_q;
    logic [1:0]        dirReqType_q;
    logic [ADDR_W-1:0] dirReqAddr_q;
    logic [DATA_W-1:0] dirReqData_q;
    logic              snpWbValid_q;
    logic [DATA_W-1:0] snpWbData_q;

    logic              fifoFull;
    logic              fifoEmpty;
    logic [ENT_W-1:0]  fifoHead;
    logic              pop_d;
    logic              push_d;

    // Request buffer; the FSM only pops from IDLE when no snoop is waiting
    assign pop_d  = (state_q == FSM_IDLE) && !snp_valid && !fifoEmpty;
    assign push_d = req_valid;

    req_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_d),
        .pop_i   (pop_d),
        .data_i  ({operationP1, addressP1, dataP1}),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Lookup of the request currently owned by the FSM
    logic [IDX_W-1:0] curIdx;
    logic [TAG_W-1:0] curTag;
    line_state_e      curState;
    logic             tagMatch;
    logic             readHit;
    logic             writeHit;
    logic             upgrade;
    logic             victimDirty;

    assign curIdx      = curAddr_q[IDX_W-1:0];
    assign curTag      = curAddr_q[ADDR_W-1:IDX_W];
    assign curState    = lineState_q[curIdx];
    assign tagMatch    = (lineTag_q[curIdx] == curTag);
    assign readHit     = !curWrite_q && tagMatch && (curState != ST_I);
    assign writeHit    = curWrite_q && tagMatch && (curState == ST_M);
    assign upgrade     = curWrite_q && tagMatch && (curState == ST_S);
    assign victimDirty = !tagMatch && (curState == ST_M);

    // Fill being installed this cycle
    logic              installNow;
    line_state_e       installState;
    logic [DATA_W-1:0] installData;

    assign installNow   = (state_q == FSM_WAIT_RESP) && dir_resp_valid;
    assign installState = curWrite_q ? ST_M : ST_S;
    assign installData  = curWrite_q ? curData_q : dir_resp_data;

    // Snoops see the line as it will be after a same-cycle install
    logic              snpAccept;
    logic [IDX_W-1:0]  snpIdx;
    logic [TAG_W-1:0]  snpTag;
    logic              sameLine;
    line_state_e       effState;
    logic [TAG_W-1:0]  effTag;
    logic [DATA_W-1:0] effData;
    logic              snpHit;
    line_state_e       snpNewState;

    assign snpAccept = snp_valid && ((state_q == FSM_IDLE) || (state_q == FSM_WAIT_RESP));
    assign snp_ready = snpAccept;
    assign snpIdx    = snp_addr[IDX_W-1:0];
    assign snpTag    = snp_addr[ADDR_W-1:IDX_W];
    assign sameLine  = installNow && (snpIdx == curIdx);
    assign effState  = sameLine ? installState : lineState_q[snpIdx];
    assign effTag    = sameLine ? curTag : lineTag_q[snpIdx];
    assign effData   = sameLine ? installData : lineData_q[snpIdx];
    assign snpHit    = (effState != ST_I) && (effTag == snpTag);

    always_comb begin
        snpNewState = effState;
        if (snp_type == SNP_INV) begin
            snpNewState = ST_I;
        end else if ((snp_type == SNP_DWN) && (effState == ST_M)) begin
            snpNewState = ST_S;
        end
    end

    // Controller FSM, line arrays and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FSM_IDLE;
            curWrite_q    <= 1'b0;
            curAddr_q     <= '0;
            curData_q     <= '0;
            rdDone_q      <= 1'b0;
            rdData_q      <= '0;
            wrDone_q      <= 1'b0;
            overflow_q    <= 1'b0;
            dirReqValid_q <= 1'b0;
            dirReqType_q  <= '0;
            dirReqAddr_q  <= '0;
            dirReqData_q  <= '0;
            snpWbValid_q  <= 1'b0;
            snpWbData_q   <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                lineState_q[i] <= ST_I;
                lineTag_q[i]   <= '0;
                lineData_q[i]  <= '0;
            end
        end else begin
            rdDone_q     <= 1'b0;
            wrDone_q     <= 1'b0;
            snpWbValid_q <= 1'b0;

            if (req_valid && fifoFull && !pop_d) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                FSM_IDLE: begin
                    if (pop_d) begin
                        curWrite_q <= fifoHead[ENT_W-1];
                        curAddr_q  <= fifoHead[ENT_W-2:DATA_W];
                        curData_q  <= fifoHead[DATA_W-1:0];
                        state_q    <= FSM_LOOKUP;
                    end
                end
                FSM_LOOKUP: begin
                    if (readHit) begin
                        rdDone_q <= 1'b1;
                        rdData_q <= lineData_q[curIdx];
                        state_q  <= FSM_IDLE;
                    end else if (writeHit) begin
                        wrDone_q           <= 1'b1;
                        lineData_q[curIdx] <= curData_q;
                        state_q            <= FSM_IDLE;
                    end else if (victimDirty) begin
                        dirReqValid_q <= 1'b1;
                        dirReqType_q  <= REQ_PUTM;
                        dirReqAddr_q  <= {lineTag_q[curIdx], curIdx};
                        dirReqData_q  <= lineData_q[curIdx];
                        state_q       <= FSM_MISS_WB;
                    end else begin
                        // Clean victims are dropped silently; an upgrade keeps its S copy
                        if (!upgrade) begin
                            lineState_q[curIdx] <= ST_I;
                        end
                        dirReqValid_q <= 1'b1;
                        dirReqType_q  <= curWrite_q ? REQ_GETM : REQ_GETS;
                        dirReqAddr_q  <= curAddr_q;
                        dirReqData_q  <= '0;
                        state_q       <= FSM_MISS_REQ;
                    end
                end
                FSM_MISS_WB: begin
                    if (dir_req_ready) begin
                        lineState_q[curIdx] <= ST_I;
                        dirReqType_q        <= curWrite_q ? REQ_GETM : REQ_GETS;
                        dirReqAddr_q        <= curAddr_q;
                        dirReqData_q        <= '0;
                        state_q             <= FSM_MISS_REQ;
                    end
                end
                FSM_MISS_REQ: begin
                    if (dir_req_ready) begin
                        dirReqValid_q <= 1'b0;
                        state_q       <= FSM_WAIT_RESP;
                    end
                end
                FSM_WAIT_RESP: begin
                    if (dir_resp_valid) begin
                        lineState_q[curIdx] <= installState;
                        lineTag_q[curIdx]   <= curTag;
                        lineData_q[curIdx]  <= installData;
                        if (curWrite_q) begin
                            wrDone_q <= 1'b1;
                        end else begin
                            rdDone_q <= 1'b1;
                            rdData_q <= dir_resp_data;
                        end
                        state_q <= FSM_IDLE;
                    end
                end
                default: state_q <= FSM_IDLE;
            endcase

            // Placed after the install so the snoop result wins on the same line
            if (snpAccept && snpHit) begin
                lineState_q[snpIdx] <= snpNewState;
                if (effState == ST_M) begin
                    snpWbValid_q <= 1'b1;
                    snpWbData_q  <= effData;
                end
            end
        end
    end

    assign rd_done       = rdDone_q;
    assign rd_data       = rdData_q;
    assign wr_done       = wrDone_q;
    assign overflow      = overflow_q;
    assign dir_req_valid = dirReqValid_q;
    assign dir_req_type  = dirReqType_q;
    assign dir_req_addr  = dirReqAddr_q;
    assign dir_req_data  = dirReqData_q;
    assign snp_wb_valid  = snpWbValid_q;
    assign snp_wb_data   = snpWbData_q;

endmodule

// File: tb/tb_p1_cache_ctrl.sv
// Directed bench for p1_cache_ctrl: a transaction table covering hits,
// fills, upgrades and writebacks, followed by hand-written sequences for
// snoops, buffer overflow, push/pop while full and reset mid-transaction.
module tb_p1_cache_ctrl;

    localparam logic [1:0] GETS = 2'b00;
    localparam logic [1:0] GETM = 2'b01;
    localparam logic [1:0] PUTM = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       operationP1 = 1'b0;
    logic [7:0] addressP1 = '0;
    logic [7:0] dataP1 = '0;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       wr_done;
    logic       overflow;
    logic       dir_req_valid;
    logic       dir_req_ready = 1'b0;
    logic [1:0] dir_req_type;
    logic [7:0] dir_req_addr;
    logic [7:0] dir_req_data;
    logic       dir_resp_valid = 1'b0;
    logic [7:0] dir_resp_data = '0;
    logic       snp_valid = 1'b0;
    logic       snp_type = 1'b0;
    logic [7:0] snp_addr = '0;
    logic       snp_ready;
    logic       snp_wb_valid;
    logic [7:0] snp_wb_data;

    int checks = 0;
    int errors = 0;

    p1_cache_ctrl #(
        .NUM_LINES  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .operationP1    (operationP1),
        .addressP1      (addressP1),
        .dataP1         (dataP1),
        .rd_done        (rd_done),
        .rd_data        (rd_data),
        .wr_done        (wr_done),
        .overflow       (overflow),
        .dir_req_valid  (dir_req_valid),
        .dir_req_ready  (dir_req_ready),
        .dir_req_type   (dir_req_type),
        .dir_req_addr   (dir_req_addr),
        .dir_req_data   (dir_req_data),
        .dir_resp_valid (dir_resp_valid),
        .dir_resp_data  (dir_resp_data),
        .snp_valid      (snp_valid),
        .snp_type       (snp_type),
        .snp_addr       (snp_addr),
        .snp_ready      (snp_ready),
        .snp_wb_valid   (snp_wb_valid),
        .snp_wb_data    (snp_wb_data)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One transaction: request, optional writeback/fetch, expected completion
    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       expWb;
        logic [7:0] wbAddr;
        logic [7:0] wbData;
        logic       expFetch;
        logic [1:0] fetchType;
        logic [7:0] fill;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs [12];

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request and play the directory until the completion pulse
    task automatic applyStimulus(input vec_t v, input int idx);
        int cyc;
        bit done;
        bit sawWb;
        bit sawFetch;
        bit wasGet;
        req_valid   = 1'b1;
        operationP1 = v.wr;
        addressP1   = v.addr;
        dataP1      = v.wdata;
        tick();
        req_valid = 1'b0;
        cyc = 0;
        done = 1'b0;
        sawWb = 1'b0;
        sawFetch = 1'b0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            dir_resp_valid = 1'b0;
            if (rd_done || wr_done) begin
                done = 1'b1;
                checkOutput($sformatf("v%0d rd_done", idx), {31'd0, rd_done}, {31'd0, !v.wr});
                checkOutput($sformatf("v%0d wr_done", idx), {31'd0, wr_done}, {31'd0, v.wr});
                if (!v.wr) begin
                    checkOutput($sformatf("v%0d rd_data", idx), {24'd0, rd_data}, {24'd0, v.expRd});
                end
                if (!v.expFetch) begin
                    checkOutput($sformatf("v%0d hit latency", idx), cyc, 2);
                end
            end else if (dir_req_valid) begin
                wasGet = (dir_req_type != PUTM);
                if (wasGet) begin
                    sawFetch = 1'b1;
                    checkOutput($sformatf("v%0d fetch type", idx), {30'd0, dir_req_type}, {30'd0, v.fetchType});
                    checkOutput($sformatf("v%0d fetch addr", idx), {24'd0, dir_req_addr}, {24'd0, v.addr});
                end else begin
                    sawWb = 1'b1;
                    checkOutput($sformatf("v%0d putm addr", idx), {24'd0, dir_req_addr}, {24'd0, v.wbAddr});
                    checkOutput($sformatf("v%0d putm data", idx), {24'd0, dir_req_data}, {24'd0, v.wbData});
                end
                dir_req_ready = 1'b1;
                tick();
                cyc++;
                dir_req_ready = 1'b0;
                if (wasGet) begin
                    checkOutput($sformatf("v%0d req dropped", idx), {31'd0, dir_req_valid}, 32'd0);
                    dir_resp_valid = 1'b1;
                    dir_resp_data  = v.fill;
                end
            end
        end
        dir_resp_valid = 1'b0;
        checkOutput($sformatf("v%0d completed", idx), {31'd0, done}, 32'd1);
        checkOutput($sformatf("v%0d writeback seen", idx), {31'd0, sawWb}, {31'd0, v.expWb});
        checkOutput($sformatf("v%0d fetch seen", idx), {31'd0, sawFetch}, {31'd0, v.expFetch});
    endtask

    // Answer every directory request for a while and count completions
    task automatic serviceAll(input int maxCyc, input logic [7:0] fill, output int nDone);
        bit respPending;
        bit wasGet;
        nDone = 0;
        respPending = 1'b0;
        for (int c = 0; c < maxCyc; c++) begin
            dir_resp_valid = respPending;
            dir_resp_data  = fill;
            respPending    = 1'b0;
            dir_req_ready  = dir_req_valid;
            wasGet = dir_req_valid && (dir_req_type != PUTM);
            tick();
            if (wasGet) begin
                respPending = 1'b1;
            end
            if (rd_done || wr_done) begin
                nDone++;
            end
        end
        dir_req_ready  = 1'b0;
        dir_resp_valid = 1'b0;
    endtask

    task automatic snoop(input logic typ, input logic [7:0] addr, input logic expWb, input logic [7:0] expData, input string name);
        snp_valid = 1'b1;
        snp_type  = typ;
        snp_addr  = addr;
        #1;
        checkOutput({name, " snp_ready"}, {31'd0, snp_ready}, 32'd1);
        tick();
        snp_valid = 1'b0;
        checkOutput({name, " snp_wb_valid"}, {31'd0, snp_wb_valid}, {31'd0, expWb});
        if (expWb) begin
            checkOutput({name, " snp_wb_data"}, {24'd0, snp_wb_data}, {24'd0, expData});
        end
        tick();
        checkOutput({name, " snp_wb pulse end"}, {31'd0, snp_wb_valid}, 32'd0);
    endtask

    initial begin
        int nDone;
        int activity;
        vec_t v;

        //         wr    addr   wdata  wb    wbAddr wbData fetch type  fill   expRd
        vecs[0]  = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, GETS, 8'hAA, 8'hAA};
        vecs[1]  = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'hAA};
        vecs[2]  = '{1'b1, 8'h04, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, GETM, 8'h55, 8'h00};
        vecs[3]  = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'h80};
        vecs[4]  = '{1'b0, 8'h08, 8'h00, 1'b1, 8'h04, 8'h80, 1'b1, GETS, 8'h31, 8'h31};
        vecs[5]  = '{1'b1, 8'h09, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1, GETM, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 8'h09, 8'h78, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'h09, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'h78};
        vecs[8]  = '{1'b0, 8'h0D, 8'h00, 1'b1, 8'h09, 8'h78, 1'b1, GETS, 8'hC3, 8'hC3};
        vecs[9]  = '{1'b0, 8'h08, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'h31};
        vecs[10] = '{1'b1, 8'h04, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, GETM, 8'hEE, 8'h00};
        vecs[11] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, GETS, 8'h5A, 8'h5A};

        // Reset state
        tick();
        tick();
        checkOutput("reset outputs", {26'd0, rd_done, wr_done, overflow, dir_req_valid, snp_ready, snp_wb_valid}, 32'd0);
        checkOutput("reset rd_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fills, hits, upgrades and writebacks
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Line 0x04 is M with 0x80: downgrade returns the dirty data, line becomes S
        snoop(1'b1, 8'h04, 1'b1, 8'h80, "dwn 0x04");
        v = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, GETS, 8'h00, 8'h80};
        applyStimulus(v, 20);
        v = '{1'b1, 8'h04, 8'h81, 1'b0, 8'h00, 8'h00, 1'b1, GETM, 8'h00, 8'h00};
        applyStimulus(v, 21);
        snoop(1'b0, 8'h0C, 1'b0, 8'h00, "inv 0x0C miss");
        snoop(1'b0, 8'h04, 1'b1, 8'h81, "inv 0x04");
        v = '{1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, GETS, 8'h44, 8'h44};
        applyStimulus(v, 22);

        // Overflow: directory stalled, six back-to-back reads
        for (int i = 0; i < 6; i++) begin
            req_valid   = 1'b1;
            operationP1 = 1'b0;
            addressP1   = 8'h0E;
            tick();
            if (i == 4) begin
                checkOutput("overflow before drop", {31'd0, overflow}, 32'd0);
            end
        end
        req_valid = 1'b0;
        checkOutput("overflow after drop", {31'd0, overflow}, 32'd1);
        checkOutput("stalled fetch addr", {24'd0, dir_req_addr}, 32'h0E);
        serviceAll(60, 8'h3C, nDone);
        checkOutput("overflow completions", nDone, 5);
        checkOutput("overflow rd_data", {24'd0, rd_data}, 32'h3C);
        checkOutput("overflow sticky", {31'd0, overflow}, 32'd1);

        // Reset while waiting on the directory with requests still queued
        req_valid = 1'b1;
        addressP1 = 8'h12;
        tick();
        addressP1 = 8'h13;
        tick();
        tick();
        req_valid = 1'b0;
        checkOutput("pre-reset fetch valid", {31'd0, dir_req_valid}, 32'd1);
        checkOutput("pre-reset fetch addr", {24'd0, dir_req_addr}, 32'h12);
        dir_req_ready = 1'b1;
        tick();
        dir_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset flags", {26'd0, rd_done, wr_done, overflow, dir_req_valid, snp_ready, snp_wb_valid}, 32'd0);
        checkOutput("async reset rd_data", {24'd0, rd_data}, 32'd0);
        checkOutput("async reset snp_wb_data", {24'd0, snp_wb_data}, 32'd0);
        checkOutput("async reset dir_req_addr", {24'd0, dir_req_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        dir_resp_valid = 1'b1;
        dir_resp_data  = 8'h77;
        tick();
        dir_resp_valid = 1'b0;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_done || wr_done || dir_req_valid) begin
                activity++;
            end
            tick();
        end
        checkOutput("post-reset activity", activity, 0);

        // Push and pop in the same cycle while full: nothing dropped
        snp_valid = 1'b1;
        snp_type  = 1'b0;
        snp_addr  = 8'h3C;
        req_valid = 1'b1;
        addressP1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        snp_valid = 1'b0;
        tick();
        req_valid = 1'b0;
        checkOutput("full push+pop overflow", {31'd0, overflow}, 32'd0);
        serviceAll(60, 8'h99, nDone);
        checkOutput("full push+pop completions", nDone, 5);
        checkOutput("full push+pop rd_data", {24'd0, rd_data}, 32'h99);
        checkOutput("full push+pop overflow end", {31'd0, overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
